bin_to_bcd_x_4: RTL and testbench
=================================

# bin_to_bcd_x_4

Sequential binary-to-BCD converter feeding the 4-digit seven-segment display driver. Accepts a 14-bit unsigned binary value on a start pulse, converts it with a shift-and-add-3 (double-dabble) iteration, one bit per clock, and presents a held 16-bit packed BCD word. Digit 0 is in [3:0] and digit 3 is in [15:12]. Inputs above 9999 are clamped to 9999 and flagged.

## Interface
- Parameters: none. Widths are fixed: 14-bit binary input, 4 BCD digits out.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- bin_in  input  14  unsigned binary value. Sampled only on the edge where start is accepted.
- start  input  1  conversion request. Accepted only when ready=1.
- ready  output  1  high when state is IDLE. Combinational decode of state.
- bcd_out  output  16  packed BCD result. Held stable between valid pulses.
- valid  output  1  one-cycle pulse. Marks that bcd_out and overflow were just updated.
- overflow  output  1  set when the converted input was >9999. Updated together with bcd_out.

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - ready=1.
  - On an edge with start=1, capture the operand into a 30-bit scratch register: BCD field [29:14]=0, binary field [13:0]=operand.
  - The operand is bin_in, or 14'd9999 if bin_in>9999.
  - Record the overflow flag internally (ovf_pending).
  - Clear the bit counter to 0 and go to SHIFT.
- SHIFT, one iteration per clock:
  - For each of the 4 BCD nibbles of scratch, if nibble ≥5, add 3. All 4 adjusts are combinational and computed in parallel from the current value.
  - Then shift the whole 30-bit value left by 1, shifting in 0, and increment the counter.
  - On the iteration where the counter is 13 (the 14th shift), do not store into scratch. Instead:
    - bcd_out ← upper 16 bits of the shifted value.
    - overflow ← ovf_pending.
    - valid ← 1.
    - Return to IDLE.
- valid is 0 on every edge that does not complete a conversion.
- start while in SHIFT is ignored. No queueing and no restart.
- start on the cycle valid is high (state is already IDLE) is accepted normally. This gives back-to-back conversions every 15 cycles.
- bin_in changing during SHIFT has no effect.
- Arithmetic rules:
  - The nibble adjust is a 4-bit add with no carry out; a nibble ≥5 plus 3 is at most 12.
  - Every nibble of bcd_out is 0–9 for every accepted input.

## Timing
- Reset state (asynchronous, while rst_n=0): state=IDLE, ready=1, bcd_out=16'h0000, valid=0, overflow=0, counter=0, scratch=0.
- rst_n asserted mid-conversion aborts the conversion immediately. No valid is produced, and bcd_out returns to 0.
- Latency: start sampled at edge N. bcd_out and overflow update, and valid rises, at edge N+14. valid falls at edge N+15.
- ready is low from edge N+1 to edge N+14, i.e. exactly 14 cycles. It is high again in the same cycle valid is high.
- bcd_out never changes except at a completing edge or at reset. The display driver may sample it at any time.

## Test plan
- Reset with rst_n=0, released mid-idle -> bcd_out=16'h0000, overflow=0, valid=0, ready=1.
- Single conversions: start with bin_in=0 -> valid exactly 14 edges later, bcd_out=16'h0000. bin_in=1234 -> 16'h1234. bin_in=9999 -> 16'h9999. overflow=0 in all three cases. ready is low for exactly 14 cycles each time.
- Clamp: bin_in=12000 (also check 16383) -> bcd_out=16'h9999, overflow=1. A following conversion of 42 -> bcd_out=16'h0042, overflow=0.
- Busy behaviour:
  - start bin_in=507, then pulse start with bin_in=8 during SHIFT -> one valid only, bcd_out=16'h0507.
  - Change bin_in during SHIFT -> result unaffected.
- Back-to-back: hold start=1 with bin_in stepping 5, 50, 500, 5000 on each accept -> a valid every 15 cycles, results 16'h0005, 16'h0050, 16'h0500, 16'h5000.
- Reset mid-conversion: start 9876, assert rst_n low at the 7th SHIFT cycle, release -> no valid, bcd_out=16'h0000. A new start with 9876 then yields 16'h9876.
- Sweep all 0–16383 against a reference model: bcd_out digits equal min(value, 9999) in decimal, and overflow = (value > 9999).

Source files
------------

// File: rtl/bin_to_bcd_x_4_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_x_4_if
// Bundles the request/result signals of the binary-to-BCD converter.
//   bin_in   [13:0] unsigned operand, sampled when start is accepted
//   start           conversion request, accepted only while ready=1
//   ready           converter is idle
//   bcd_out  [15:0] packed BCD result, digit 0 in [3:0], digit 3 in [15:12]
//   valid           one-cycle pulse: bcd_out/overflow were just updated
//   overflow        the converted operand was above 9999 (result clamped)
// Handshake: a request transfers on a rising clk edge where start=1 and
// ready=1; start with ready=0 is dropped (no queueing). valid is a pulse
// with no back-pressure; the result stays held until the next valid.
// master = requester (drives bin_in/start), slave = converter.
// ---------------------------------------------------------------------------
interface bin_to_bcd_x_4_if;
    logic [13:0] bin_in;
    logic        start;
    logic        ready;
    logic [15:0] bcd_out;
    logic        valid;
    logic        overflow;

    modport master (
        output bin_in, start,
        input  ready, bcd_out, valid, overflow
    );

    modport slave (
        input  bin_in, start,
        output ready, bcd_out, valid, overflow
    );
endinterface

// File: rtl/bin_to_bcd_x_4.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_x_4
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble,
// one bit per clock). Operands above 9999 are clamped to 9999 and flagged.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          bin_to_bcd_x_4_if.slave (bin_in/start in, ready/bcd_out/
//                valid/overflow out)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = SHIFT)
// Timing: start accepted at edge N -> valid/bcd_out/overflow at edge N+14,
// ready low for exactly 14 cycles, back-to-back conversions every 15 cycles.
// ---------------------------------------------------------------------------
module bin_to_bcd_x_4 (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_x_4_if.slave   bus,
    output logic              o_dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    // [29:14] four BCD digits being built, [13:0] remaining binary bits
    logic [29:0] r_scratch, w_scratch_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_ovf_pending, w_ovf_pending_nxt;
    logic [15:0] r_bcd, w_bcd_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_overflow, w_overflow_nxt;

    logic [29:0] w_adj;
    logic [29:0] w_shifted;
    logic        w_clamp;

    // Add-3 correction on every BCD nibble that would reach >=10 after the
    // doubling shift. 4-bit wrap is safe: a nibble >=5 plus 3 is at most 12.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[14 + 4*i +: 4] >= 4'd5) begin
                w_adj[14 + 4*i +: 4] = r_scratch[14 + 4*i +: 4] + 4'd3;
            end
        end
        w_shifted = w_adj << 1;
    end

    assign w_clamp = (bus.bin_in > 14'd9999);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_scratch     <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= 1'b0;
            r_bcd         <= '0;
            r_valid       <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_scratch     <= w_scratch_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ovf_pending <= w_ovf_pending_nxt;
            r_bcd         <= w_bcd_nxt;
            r_valid       <= w_valid_nxt;
            r_overflow    <= w_overflow_nxt;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        w_state_nxt       = r_state;
        w_scratch_nxt     = r_scratch;
        w_cnt_nxt         = r_cnt;
        w_ovf_pending_nxt = r_ovf_pending;
        w_bcd_nxt         = r_bcd;
        w_valid_nxt       = 1'b0;
        w_overflow_nxt    = r_overflow;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_scratch_nxt     = {16'd0, (w_clamp ? 14'd9999 : bus.bin_in)};
                    w_ovf_pending_nxt = w_clamp;
                    w_cnt_nxt         = 4'd0;
                    w_state_nxt       = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == 4'd13) begin
                    // 14th shift: publish straight from the shifted value
                    w_bcd_nxt      = w_shifted[29:14];
                    w_overflow_nxt = r_ovf_pending;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_scratch_nxt = w_shifted;
                    w_cnt_nxt     = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ready    = (r_state == S_IDLE);
    assign bus.bcd_out  = r_bcd;
    assign bus.valid    = r_valid;
    assign bus.overflow = r_overflow;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bin_to_bcd_x_4.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_x_4
// Self-checking bench for bin_to_bcd_x_4: directed cases plus randomized
// operands, results compared against a decimal-arithmetic reference model
// through an expected queue popped on every valid pulse.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_x_4;

    logic clk;
    logic rst_n;
    logic dbg_state;

    int checks;
    int errors;
    int cyc;
    int n_valid;

    // {overflow, bcd_out}
    logic [16:0] exp_q[$];
    logic [15:0] prev_bcd;

    bin_to_bcd_x_4_if bus ();

    bin_to_bcd_x_4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: clamp, then split into decimal digits with plain arithmetic.
    function automatic logic [16:0] ref_model(input int v);
        int c;
        logic [15:0] b;
        c = (v > 9999) ? 9999 : v;
        b = 16'((c / 1000) * 4096 + ((c / 100) % 10) * 256 + ((c / 10) % 10) * 16 + (c % 10));
        return {(v > 9999), b};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_bcd = bus.bcd_out;
        end else if (bus.valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(bus.valid), 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("bcd_out", 32'(bus.bcd_out), 32'(e[15:0]));
                check("overflow", 32'(bus.overflow), 32'(e[16]));
            end
            prev_bcd = bus.bcd_out;
        end else if (bus.bcd_out !== prev_bcd) begin
            check("bcd_hold", 32'(bus.bcd_out), 32'(prev_bcd));
            prev_bcd = bus.bcd_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready_negedge();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // One conversion with latency and ready-low accounting; bin_in is
    // scrambled during SHIFT to show it is ignored.
    task automatic run_conv(input int val);
        int lat;
        int lows;
        wait_ready_negedge();
        bus.bin_in = 14'(val);
        bus.start  = 1'b1;
        @(posedge clk);
        exp_q.push_back(ref_model(val));
        #1;
        bus.start  = 1'b0;
        bus.bin_in = 14'($urandom_range(0, 16383));
        lows = bus.ready ? 0 : 1;
        lat  = 0;
        while (!bus.valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.ready) lows++;
            if (lat == 5) bus.bin_in = 14'($urandom_range(0, 16383));
        end
        check("latency", 32'(lat), 32'd14);
        check("ready_low_cycles", 32'(lows), 32'd14);
        check("ready_with_valid", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        check("valid_pulse_fall", 32'(bus.valid), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int vals[4];
        int acc_cyc[4];
        int nv0;

        checks = 0; errors = 0; cyc = 0; n_valid = 0; prev_bcd = '0;
        bus.bin_in = 14'd0;
        bus.start  = 1'b0;
        rst_n      = 1'b0;

        // Reset state
        #23;
        check("rst_bcd", 32'(bus.bcd_out), 32'h0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd1);

        // Directed single conversions and clamp
        run_conv(0);
        run_conv(1234);
        run_conv(9999);
        run_conv(12000);
        run_conv(16383);
        run_conv(42);
        run_conv(10000);
        run_conv(9998);

        // Busy: a second start during SHIFT is dropped
        nv0 = n_valid;
        wait_ready_negedge();
        bus.bin_in = 14'd507;
        bus.start  = 1'b1;
        @(posedge clk);
        exp_q.push_back(ref_model(507));
        #1;
        bus.start = 1'b0;
        check("shift_state", 32'(dbg_state), 32'd1);
        repeat (4) @(negedge clk);
        bus.bin_in = 14'd8;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (25) @(negedge clk);
        check("busy_one_valid", 32'(n_valid - nv0), 32'd1);

        // Back-to-back with start held high
        vals = '{5, 50, 500, 5000};
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (!bus.ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            bus.bin_in = 14'(vals[k]);
            @(posedge clk);
            exp_q.push_back(ref_model(vals[k]));
            acc_cyc[k] = cyc;
            @(negedge clk);
        end
        bus.start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd15);
        end
        repeat (20) @(negedge clk);

        // Reset in the middle of a conversion
        nv0 = n_valid;
        wait_ready_negedge();
        bus.bin_in = 14'd9876;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_bcd", 32'(bus.bcd_out), 32'h0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_valid", 32'(n_valid - nv0), 32'd0);
        check("abort_bcd_held", 32'(bus.bcd_out), 32'h0);
        run_conv(9876);

        // Randomized operands, biased toward the clamp boundary
        for (int i = 0; i < 1500; i++) begin
            int v;
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(9990, 10010));
            else                           v = int'($urandom_range(0, 16383));
            run_conv(v);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
